mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder that serves the multicycle CPU's load/store and instruction-fetch requests over a valid/ready handshake. It owns a word-organised RAM plus a read-only exception-vector word at byte address 252, whose bytes [15:8] and [7:0] the CPU's exception sequence fetches as handler addresses. It inserts a configurable number of wait states and reports misaligned, out-of-range and vector-write accesses as faults, so the control unit can raise an exception instead of corrupting memory.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; byte span is 4*DEPTH_WORDS.
- `WAIT_STATES`, 1: cycles spent in WAIT per access; 0..15 legal.
- `VEC_ADDR`, 252: byte address of the read-only vector word; must be word-aligned and < 4*DEPTH_WORDS.
- `VEC_INIT`, 32'h0000_FEFF: vector word value after reset; the two handler bytes are 254 (bits [15:8]) and 255 (bits [7:0]).

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: the CPU presents a request.
- `req_wr`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: write data.
- `req_ready`, out, 1: the responder accepts a request this cycle.
- `rsp_valid`, out, 1: one-cycle pulse marking completion.
- `rsp_rdata`, out, 32: read data; 0 for writes and faults.
- `rsp_fault`, out, 1: the access was rejected; valid while `rsp_valid` is high.

## Operation
- States: IDLE, WAIT, RESPOND (enum).
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch addr, wr and wdata, and compute the fault flag.
  - Next state is WAIT with counter = WAIT_STATES, or RESPOND directly if WAIT_STATES = 0.
- **Fault conditions** (any of):
  - `addr[1:0]` != 0;
  - `addr` >= 4*DEPTH_WORDS;
  - write with `addr` == VEC_ADDR.
- **WAIT**
  - `req_ready` = 0.
  - Counter decrements each cycle.
  - Leave for RESPOND in the cycle the counter reads 1.
- **RESPOND**
  - `rsp_valid` = 1 and `req_ready` = 0; next state is IDLE.
  - Non-faulting write: RAM word `addr[31:2]` takes `wdata` at this edge; `rsp_rdata` = 0.
  - Non-faulting read: `rsp_rdata` = the vector register if `addr` == VEC_ADDR, otherwise the RAM word `addr[31:2]`.
  - Fault: no write, `rsp_rdata` = 0, `rsp_fault` = 1.
- The vector word lives in a dedicated register, never in RAM. The RAM entry at the same index is unused.
- RAM contents are not reset. The vector register resets to VEC_INIT.

## Timing
- **Reset values:** state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_fault` 0, `rsp_rdata` 0, counter 0.
- **Latency:** a request accepted at edge T gets `rsp_valid` during the cycle after edge T+1+WAIT_STATES. With WAIT_STATES = 1, the response comes 2 cycles after acceptance.
- **Throughput:** one access per WAIT_STATES+2 cycles. The IDLE cycle after RESPOND is mandatory, and no request is accepted while RESPOND is active.
- **Request signals:** `req_*` are sampled only in IDLE. The CPU may change them after acceptance without effect.
- **Output registers:**
  - `rsp_rdata` and `rsp_fault` are registered.
  - `rsp_rdata` holds its value until the next RESPOND or reset.
  - `rsp_fault` clears in the cycle after RESPOND.
- **Read-after-write:** a read of the same word accepted in the IDLE cycle right after a write's RESPOND returns the new data.
- **Reset mid-operation:** reset asserted in WAIT or RESPOND returns the block to IDLE on the next edge.
  - `rsp_valid` stays 0.
  - A pending write whose RESPOND edge coincides with reset is dropped (reset has priority).
- **Counter width:** 4 bits. WAIT_STATES = 0 bypasses WAIT entirely.

## Structure
- Package `mem_responder_pkg`:
  - `resp_state_t` enum {IDLE, WAIT, RESPOND};
  - localparam `VEC_ADDR_DEFAULT` = 252;
  - fault-reason constants FAULT_ALIGN, FAULT_RANGE, FAULT_RO, kept for a later cause-register hookup.
- Sub-module `word_ram`: DEPTH_WORDS×32, synchronous write, combinational read, no reset.
- The top contains the FSM, latches, fault logic, vector register and output registers.

## Test plan
- Reset, then read at 252 -> after 2 cycles `rsp_valid`=1, `rsp_rdata`=32'h0000_FEFF, `rsp_fault`=0.
- Write 0xDEADBEEF to address 16, then read address 16 -> the write's rsp has `rdata`=0; the read returns 0xDEADBEEF. Also check `req_ready` is 0 in WAIT/RESPOND and 1 in the gap cycle.
- Read at 6, then read at 256 -> both give `rsp_fault`=1 and `rdata`=0; RAM is unchanged afterwards.
- Write 0x12345678 to 252 -> `rsp_fault`=1; a later read of 252 still returns 0x0000FEFF.
- WAIT_STATES=0: read accepted at edge T gives `rsp_valid` in the cycle after edge T+1. WAIT_STATES=3: `rsp_valid` in the cycle after edge T+4.
- Write to 20 with reset pulsed during WAIT -> no `rsp_valid` pulse; a later read of 20 returns the prior contents; state is back in IDLE with `req_ready`=1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
// Fault-reason codes are reserved for a later cause register.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } resp_state_t;

    localparam int unsigned VEC_ADDR_DEFAULT = 252;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_ALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE = 2'd2;
    localparam logic [1:0] FAULT_RO    = 2'd3;

endpackage

// File: rtl/word_ram.sv
// Word-organised RAM: synchronous write, combinational read, no reset.
module word_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle CPU: valid/ready request, wait states,
// registered response, read-only exception-vector word and access faults.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] VEC_ADDR    = 32'(VEC_ADDR_DEFAULT),
    parameter logic [31:0] VEC_INIT    = 32'h0000_FEFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BYTE_SPAN = 32'(4 * DEPTH_WORDS);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] vec_q;

    logic [31:0] cur_addr;
    logic        cur_wr;
    logic        cur_fault;
    logic [31:0] ram_rdata;
    logic        ram_we;

    function automatic logic is_fault(input logic [31:0] addr, input logic wr);
        return (addr[1:0] != 2'b00) || (addr >= BYTE_SPAN) || (wr && (addr == VEC_ADDR));
    endfunction

    // With zero wait states the response is built from the live request, otherwise from the latches.
    assign cur_addr  = (state_q == IDLE) ? req_addr : addr_q;
    assign cur_wr    = (state_q == IDLE) ? req_wr : wr_q;
    assign cur_fault = (state_q == IDLE) ? is_fault(req_addr, req_wr) : fault_q;

    // Reset wins over a write whose RESPOND edge coincides with it.
    assign ram_we = (state_q == RESPOND) && wr_q && !fault_q && !reset;

    word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clock  (clock),
        .we_i   (ram_we),
        .waddr_i(addr_q[AW+1:2]),
        .wdata_i(wdata_q),
        .raddr_i(cur_addr[AW+1:2]),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        rsp_fault_d = rsp_fault_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    fault_d = cur_fault;
                    if (WAIT_STATES == 0) begin
                        state_d = RESPOND;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESPOND;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                rsp_valid   = 1'b1;
                rsp_fault_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != RESPOND) && (state_d == RESPOND)) begin
            rsp_fault_d = cur_fault;
            if (cur_fault || cur_wr) begin
                rdata_d = 32'd0;
            end else if (cur_addr == VEC_ADDR) begin
                rdata_d = vec_q;
            end else begin
                rdata_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
            rsp_fault_q <= 1'b0;
            vec_q       <= VEC_INIT;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            rsp_fault_q <= rsp_fault_d;
            vec_q       <= vec_q;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at 0, 1 and 3 wait states; expected
// responses are queued when a request is driven and popped at rsp_valid.
module tb_mem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWr = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWdata = 32'd0;
    int          sel = 1;

    logic        reqValid0, reqValid1, reqValid3;
    logic        ready0, ready1, ready3;
    logic        valid0, valid1, valid3;
    logic        fault0, fault1, fault3;
    logic [31:0] rdata0, rdata1, rdata3;

    logic        obsReady, obsValid, obsFault;
    logic [31:0] obsRdata;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    assign reqValid0 = reqValid && (sel == 0);
    assign reqValid1 = reqValid && (sel == 1);
    assign reqValid3 = reqValid && (sel == 3);

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(reqValid0), .req_wr(reqWr),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready0),
        .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_fault(fault0)
    );

    mem_responder #(.WAIT_STATES(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(reqValid1), .req_wr(reqWr),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready1),
        .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_fault(fault1)
    );

    mem_responder #(.WAIT_STATES(3)) dut3 (
        .clock(clock), .reset(reset), .req_valid(reqValid3), .req_wr(reqWr),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready3),
        .rsp_valid(valid3), .rsp_rdata(rdata3), .rsp_fault(fault3)
    );

    always_comb begin
        obsReady = ready1;
        obsValid = valid1;
        obsFault = fault1;
        obsRdata = rdata1;
        if (sel == 0) begin
            obsReady = ready0;
            obsValid = valid0;
            obsFault = fault0;
            obsRdata = rdata0;
        end else if (sel == 3) begin
            obsReady = ready3;
            obsValid = valid3;
            obsFault = fault3;
            obsRdata = rdata3;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete access on the selected instance (sel equals its wait-state count).
    task automatic applyStimulus(input string name, input int dut, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expFault);
        exp_t e;
        int   n;
        sel = dut;
        #1;
        checkOutput({name, "/ready_idle"}, 32'(obsReady), 32'd1);
        e.rdata = expRdata;
        e.fault = expFault;
        expQ.push_back(e);
        reqValid = 1'b1;
        reqWr    = wr;
        reqAddr  = addr;
        reqWdata = wdata;
        tick();
        reqValid = 1'b0;
        reqWr    = ~wr;
        reqAddr  = addr ^ 32'h0000_0004;
        reqWdata = ~wdata;
        n = 1;
        while (!obsValid && n < 20) begin
            checkOutput({name, "/ready_busy"}, 32'(obsReady), 32'd0);
            tick();
            n++;
        end
        if (!obsValid) begin
            checkOutput({name, "/rsp_timeout"}, 32'(obsValid), 32'd1);
            void'(expQ.pop_front());
            return;
        end
        checkOutput({name, "/latency"}, 32'(n), 32'(dut + 1));
        checkOutput({name, "/ready_respond"}, 32'(obsReady), 32'd0);
        e = expQ.pop_front();
        checkOutput({name, "/rsp_rdata"}, obsRdata, e.rdata);
        checkOutput({name, "/rsp_fault"}, 32'(obsFault), 32'(e.fault));
        tick();
        checkOutput({name, "/gap_valid"}, 32'(obsValid), 32'd0);
        checkOutput({name, "/gap_fault"}, 32'(obsFault), 32'd0);
        checkOutput({name, "/gap_ready"}, 32'(obsReady), 32'd1);
        checkOutput({name, "/rdata_hold"}, obsRdata, e.rdata);
    endtask

    initial begin
        repeat (3) tick();
        checkOutput("reset/ready", 32'(obsReady), 32'd1);
        checkOutput("reset/valid", 32'(obsValid), 32'd0);
        checkOutput("reset/fault", 32'(obsFault), 32'd0);
        checkOutput("reset/rdata", obsRdata, 32'd0);
        reset = 1'b0;
        tick();

        applyStimulus("vec_read",    1, 1'b0, 32'd252, 32'd0,         32'h0000_FEFF, 1'b0);
        applyStimulus("wr16",        1, 1'b1, 32'd16,  32'hDEAD_BEEF, 32'd0,         1'b0);
        applyStimulus("raw16",       1, 1'b0, 32'd16,  32'd0,         32'hDEAD_BEEF, 1'b0);
        applyStimulus("misalign6",   1, 1'b0, 32'd6,   32'd0,         32'd0,         1'b1);
        applyStimulus("range256",    1, 1'b0, 32'd256, 32'd0,         32'd0,         1'b1);
        applyStimulus("misalign_wr", 1, 1'b1, 32'd18,  32'hAAAA_5555, 32'd0,         1'b1);
        applyStimulus("reread16",    1, 1'b0, 32'd16,  32'd0,         32'hDEAD_BEEF, 1'b0);
        applyStimulus("vec_write",   1, 1'b1, 32'd252, 32'h1234_5678, 32'd0,         1'b1);
        applyStimulus("vec_reread",  1, 1'b0, 32'd252, 32'd0,         32'h0000_FEFF, 1'b0);
        applyStimulus("wr248",       1, 1'b1, 32'd248, 32'hCAFE_F00D, 32'd0,         1'b0);
        applyStimulus("rd248",       1, 1'b0, 32'd248, 32'd0,         32'hCAFE_F00D, 1'b0);
        applyStimulus("wr0",         1, 1'b1, 32'd0,   32'h0BAD_C0DE, 32'd0,         1'b0);
        applyStimulus("rd0",         1, 1'b0, 32'd0,   32'd0,         32'h0BAD_C0DE, 1'b0);

        applyStimulus("ws0_vec",     0, 1'b0, 32'd252, 32'd0,         32'h0000_FEFF, 1'b0);
        applyStimulus("ws0_wr8",     0, 1'b1, 32'd8,   32'h0102_0304, 32'd0,         1'b0);
        applyStimulus("ws0_rd8",     0, 1'b0, 32'd8,   32'd0,         32'h0102_0304, 1'b0);
        applyStimulus("ws0_range",   0, 1'b0, 32'd300, 32'd0,         32'd0,         1'b1);
        applyStimulus("ws3_vec",     3, 1'b0, 32'd252, 32'd0,         32'h0000_FEFF, 1'b0);
        applyStimulus("ws3_wr12",    3, 1'b1, 32'd12,  32'h5A5A_A5A5, 32'd0,         1'b0);
        applyStimulus("ws3_rd12",    3, 1'b0, 32'd12,  32'd0,         32'h5A5A_A5A5, 1'b0);

        applyStimulus("wr20",        1, 1'b1, 32'd20,  32'h1111_2222, 32'd0,         1'b0);
        sel = 1;
        reqValid = 1'b1;
        reqWr    = 1'b1;
        reqAddr  = 32'd20;
        reqWdata = 32'h3333_4444;
        tick();
        reqValid = 1'b0;
        checkOutput("rst_wait/busy", 32'(obsReady), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_wait/valid", 32'(obsValid), 32'd0);
        checkOutput("rst_wait/ready", 32'(obsReady), 32'd1);
        checkOutput("rst_wait/rdata", obsRdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_wait/no_pulse", 32'(obsValid), 32'd0);
        end

        reqValid = 1'b1;
        reqWr    = 1'b1;
        reqAddr  = 32'd20;
        reqWdata = 32'h5555_6666;
        tick();
        reqValid = 1'b0;
        tick();
        checkOutput("rst_rsp/reached", 32'(obsValid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_rsp/valid", 32'(obsValid), 32'd0);
        checkOutput("rst_rsp/ready", 32'(obsReady), 32'd1);
        applyStimulus("rd20_after_rst", 1, 1'b0, 32'd20, 32'd0, 32'h1111_2222, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
